iob_native_rr_arbiter: RTL and testbench

//  N-master to 1-slave round-robin arbiter for the IOb native bus (avalid/addr/wdata/wstrb/rdata/rvalid/ready).

---
 rtl/iob_native_rr_arbiter_pkg.sv | 18 +
 rtl/iob_native_id_fifo.sv | 59 +++++
 rtl/iob_native_rr_arbiter.sv | 144 ++++++++++++++
 tb/tb_iob_native_rr_arbiter.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iob_native_rr_arbiter_pkg.sv
// Shared types and width helpers for the IOb native round-robin arbiter.
package iob_native_rr_arbiter_pkg;

  typedef enum logic {
    REQ_WRITE = 1'b0,
    REQ_READ  = 1'b1
  } req_kind_e;

  // Master index width; kept at least 1 bit so single-bit vectors stay legal.
  function automatic int id_width(input int n_masters);
    return (n_masters > 1) ? $clog2(n_masters) : 1;
  endfunction

  function automatic int strb_width(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/iob_native_id_fifo.sv
// Show-ahead FIFO of master IDs for reads that are still waiting for rvalid.
module iob_native_id_fifo
  import iob_native_rr_arbiter_pkg::*;
#(
  parameter int ID_W  = 1,
  parameter int DEPTH = 4
) (
  input  logic            clk_i,
  input  logic            arst_n_i,
  input  logic            push_i,
  input  logic            pop_i,
  input  logic [ID_W-1:0] din_i,
  output logic [ID_W-1:0] head_o,
  output logic            full_o,
  output logic            empty_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [ID_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count == (PTR_W + 1)'(DEPTH));
  assign empty_o = (count == '0);
  assign head_o  = mem[rd_ptr];

  // A push while full is legal only when the same cycle pops the head.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din_i;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/iob_native_rr_arbiter.sv
// N-master to 1-slave round-robin arbiter for the IOb native bus; read
// responses are steered back to the issuing master through an ID FIFO.
module iob_native_rr_arbiter
  import iob_native_rr_arbiter_pkg::*;
#(
  parameter int N_MASTERS       = 2,
  parameter int ADDR_W          = 16,
  parameter int DATA_W          = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                            clk_i,
  input  logic                            arst_n_i,
  input  logic [N_MASTERS-1:0]            m_avalid_i,
  input  logic [N_MASTERS*ADDR_W-1:0]     m_addr_i,
  input  logic [N_MASTERS*DATA_W-1:0]     m_wdata_i,
  input  logic [N_MASTERS*(DATA_W/8)-1:0] m_wstrb_i,
  output logic [N_MASTERS-1:0]            m_ready_o,
  output logic [DATA_W-1:0]               m_rdata_o,
  output logic [N_MASTERS-1:0]            m_rvalid_o,
  output logic                            s_avalid_o,
  output logic [ADDR_W-1:0]               s_addr_o,
  output logic [DATA_W-1:0]               s_wdata_o,
  output logic [DATA_W/8-1:0]             s_wstrb_o,
  input  logic                            s_ready_i,
  input  logic [DATA_W-1:0]               s_rdata_i,
  input  logic                            s_rvalid_i,
  output logic                            err_o
);

  localparam int ID_W   = id_width(N_MASTERS);
  localparam int STRB_W = strb_width(DATA_W);

  logic [ID_W-1:0]      rr_ptr;
  logic [ID_W-1:0]      lock_id;
  logic                 lock;
  logic [ID_W-1:0]      grant;
  logic [ID_W-1:0]      next_ptr;
  logic [ID_W:0]        scan_idx;
  logic                 found;
  logic [N_MASTERS-1:0] is_read;
  logic [N_MASTERS-1:0] eligible;
  req_kind_e            grant_kind;
  logic                 accept;
  logic                 read_blocked;
  logic                 fifo_push;
  logic                 fifo_pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [ID_W-1:0]      fifo_head;

  assign fifo_pop     = s_rvalid_i && !fifo_empty;
  assign read_blocked = fifo_full && !fifo_pop;

  // Reads are only eligible while the ID FIFO can take another entry, so
  // writes from other masters keep flowing when reads back up.
  for (genvar k = 0; k < N_MASTERS; k++) begin : g_req
    assign is_read[k]  = (m_wstrb_i[k*STRB_W +: STRB_W] == '0);
    assign eligible[k] = m_avalid_i[k] && !(is_read[k] && read_blocked);
  end

  always_comb begin
    found    = 1'b0;
    grant    = rr_ptr;
    scan_idx = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      scan_idx = {1'b0, rr_ptr} + (ID_W + 1)'(i);
      if (scan_idx >= (ID_W + 1)'(N_MASTERS)) begin
        scan_idx = scan_idx - (ID_W + 1)'(N_MASTERS);
      end
      if (!found && eligible[scan_idx[ID_W-1:0]]) begin
        found = 1'b1;
        grant = scan_idx[ID_W-1:0];
      end
    end
    if (lock) begin
      grant = lock_id;
      found = eligible[lock_id];
    end
  end

  assign s_avalid_o = found;
  assign accept     = s_avalid_o && s_ready_i;
  assign grant_kind = is_read[grant] ? REQ_READ : REQ_WRITE;
  assign fifo_push  = accept && (grant_kind == REQ_READ);
  assign next_ptr   = (grant == ID_W'(N_MASTERS - 1)) ? '0 : grant + 1'b1;

  always_comb begin
    s_addr_o  = '0;
    s_wdata_o = '0;
    s_wstrb_o = '0;
    m_ready_o = '0;
    if (s_avalid_o) begin
      s_addr_o         = m_addr_i[int'(grant)*ADDR_W +: ADDR_W];
      s_wdata_o        = m_wdata_i[int'(grant)*DATA_W +: DATA_W];
      s_wstrb_o        = m_wstrb_i[int'(grant)*STRB_W +: STRB_W];
      m_ready_o[grant] = s_ready_i;
    end
  end

  assign m_rdata_o = s_rdata_i;

  always_comb begin
    m_rvalid_o = '0;
    if (fifo_pop) begin
      m_rvalid_o[fifo_head] = 1'b1;
    end
  end

  // A stalled request pins the grant so the slave sees stable fields.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      rr_ptr  <= '0;
      lock    <= 1'b0;
      lock_id <= '0;
      err_o   <= 1'b0;
    end else begin
      if (accept) begin
        rr_ptr <= next_ptr;
        lock   <= 1'b0;
      end else if (s_avalid_o) begin
        lock    <= 1'b1;
        lock_id <= grant;
      end
      if (s_rvalid_i && fifo_empty) begin
        err_o <= 1'b1;
      end
    end
  end

  iob_native_id_fifo #(
    .ID_W  (ID_W),
    .DEPTH (MAX_OUTSTANDING)
  ) u_id_fifo (
    .clk_i    (clk_i),
    .arst_n_i (arst_n_i),
    .push_i   (fifo_push),
    .pop_i    (fifo_pop),
    .din_i    (grant),
    .head_o   (fifo_head),
    .full_o   (fifo_full),
    .empty_o  (fifo_empty)
  );

endmodule

// File: tb/tb_iob_native_rr_arbiter.sv
// Directed and randomized checks of iob_native_rr_arbiter against a
// queue-based transaction model of the round-robin arbiter.
module tb_iob_native_rr_arbiter;

  localparam int N     = 2;
  localparam int AW    = 16;
  localparam int DW    = 32;
  localparam int SW    = DW / 8;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    m_avalid;
  logic [N*AW-1:0] m_addr;
  logic [N*DW-1:0] m_wdata;
  logic [N*SW-1:0] m_wstrb;
  logic [N-1:0]    m_ready;
  logic [DW-1:0]   m_rdata;
  logic [N-1:0]    m_rvalid;
  logic            s_avalid;
  logic [AW-1:0]   s_addr;
  logic [DW-1:0]   s_wdata;
  logic [SW-1:0]   s_wstrb;
  logic            s_ready;
  logic [DW-1:0]   s_rdata;
  logic            s_rvalid;
  logic            err;

  always #5 clk = ~clk;

  iob_native_rr_arbiter #(
    .N_MASTERS       (N),
    .ADDR_W          (AW),
    .DATA_W          (DW),
    .MAX_OUTSTANDING (DEPTH)
  ) u_dut (
    .clk_i      (clk),
    .arst_n_i   (rst_n),
    .m_avalid_i (m_avalid),
    .m_addr_i   (m_addr),
    .m_wdata_i  (m_wdata),
    .m_wstrb_i  (m_wstrb),
    .m_ready_o  (m_ready),
    .m_rdata_o  (m_rdata),
    .m_rvalid_o (m_rvalid),
    .s_avalid_o (s_avalid),
    .s_addr_o   (s_addr),
    .s_wdata_o  (s_wdata),
    .s_wstrb_o  (s_wstrb),
    .s_ready_i  (s_ready),
    .s_rdata_i  (s_rdata),
    .s_rvalid_i (s_rvalid),
    .err_o      (err)
  );

  // Transaction-level model: outstanding read owners in issue order,
  // next master to favour, master holding a stalled request, sticky error.
  int id_q[$];
  int rr_ptr;
  int lock_m;
  bit err_m;

  bit            exp_valid;
  int            exp_g;
  bit            exp_pop;
  logic [N-1:0]  exp_ready;
  logic [N-1:0]  exp_rvalid;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_wdata;
  logic [SW-1:0] exp_wstrb;

  int n_vectors     = 0;
  int n_miscompares = 0;

  logic [SW-1:0] rnd_strb;

  function automatic bit wants(input int k, input bit can_read);
    logic [SW-1:0] st;
    st = m_wstrb[k*SW +: SW];
    return m_avalid[k] && ((st != '0) || can_read);
  endfunction

  task automatic modelReset();
    id_q.delete();
    rr_ptr = 0;
    lock_m = -1;
    err_m  = 1'b0;
  endtask

  task automatic predict();
    bit can_read;
    exp_pop   = s_rvalid && (id_q.size() > 0);
    can_read  = (id_q.size() < DEPTH) || exp_pop;
    exp_valid = 1'b0;
    exp_g     = 0;
    if (lock_m >= 0) begin
      exp_g     = lock_m;
      exp_valid = wants(lock_m, can_read);
    end else begin
      for (int i = 0; i < N; i++) begin
        if (!exp_valid && wants((rr_ptr + i) % N, can_read)) begin
          exp_valid = 1'b1;
          exp_g     = (rr_ptr + i) % N;
        end
      end
    end
    exp_addr  = exp_valid ? m_addr[exp_g*AW +: AW]  : '0;
    exp_wdata = exp_valid ? m_wdata[exp_g*DW +: DW] : '0;
    exp_wstrb = exp_valid ? m_wstrb[exp_g*SW +: SW] : '0;
    exp_ready = '0;
    if (exp_valid && s_ready) exp_ready[exp_g] = 1'b1;
    exp_rvalid = '0;
    if (exp_pop) exp_rvalid[id_q[0]] = 1'b1;
  endtask

  task automatic commit();
    if (s_rvalid && id_q.size() == 0) err_m = 1'b1;
    if (exp_pop) void'(id_q.pop_front());
    if (exp_valid && s_ready) begin
      if (m_wstrb[exp_g*SW +: SW] == '0) id_q.push_back(exp_g);
      rr_ptr = (exp_g + 1) % N;
      lock_m = -1;
    end else if (exp_valid) begin
      lock_m = exp_g;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    n_vectors++;
    assert (observed === expected) else begin
      n_miscompares++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, ".s_avalid"}, 64'(s_avalid), 64'(exp_valid));
    checkOutput({tag, ".s_addr"},   64'(s_addr),   64'(exp_addr));
    checkOutput({tag, ".s_wdata"},  64'(s_wdata),  64'(exp_wdata));
    checkOutput({tag, ".s_wstrb"},  64'(s_wstrb),  64'(exp_wstrb));
    checkOutput({tag, ".m_ready"},  64'(m_ready),  64'(exp_ready));
    checkOutput({tag, ".m_rvalid"}, 64'(m_rvalid), 64'(exp_rvalid));
    checkOutput({tag, ".m_rdata"},  64'(m_rdata),  64'(s_rdata));
    checkOutput({tag, ".err"},      64'(err),      64'(err_m));
  endtask

  task automatic setMaster(input int k, input bit v, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic [SW-1:0] s);
    m_avalid[k]         = v;
    m_addr[k*AW +: AW]  = a;
    m_wdata[k*DW +: DW] = d;
    m_wstrb[k*SW +: SW] = s;
  endtask

  task automatic idleMasters();
    m_avalid = '0;
    m_addr   = '0;
    m_wdata  = '0;
    m_wstrb  = '0;
  endtask

  task automatic applyStimulus(input string tag);
    #2;
    predict();
    checkAll(tag);
  endtask

  task automatic tick();
    predict();
    @(posedge clk);
    commit();
    #1;
  endtask

  task automatic doReset(input string tag);
    idleMasters();
    s_ready  = 1'b0;
    s_rvalid = 1'b0;
    s_rdata  = '0;
    rst_n    = 1'b0;
    modelReset();
    #2;
    predict();
    checkAll(tag);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    // 1: reset and idle
    doReset("t1_reset");
    applyStimulus("t1_idle");
    checkOutput("t1_s_avalid", 64'(s_avalid), 64'd0);
    checkOutput("t1_err", 64'(err), 64'd0);
    tick();

    // 2: two writers, grants alternate
    setMaster(0, 1'b1, 16'h1000, 32'h1111_1111, 4'hF);
    setMaster(1, 1'b1, 16'h2000, 32'h2222_2222, 4'hF);
    s_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      applyStimulus("t2");
      checkOutput("t2_grant", 64'(m_ready), (c % 2 == 0) ? 64'd1 : 64'd2);
      tick();
    end

    // 3: stalled read from M1 holds the grant against M0
    idleMasters();
    setMaster(1, 1'b1, 16'h0010, 32'h0, 4'h0);
    s_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      applyStimulus("t3_stall");
      checkOutput("t3_addr", 64'(s_addr), 64'h0010);
      checkOutput("t3_ready", 64'(m_ready), 64'd0);
      tick();
      setMaster(0, 1'b1, 16'h3000, 32'h3333_3333, 4'hF);
    end
    s_ready = 1'b1;
    applyStimulus("t3_accept");
    checkOutput("t3_accept", 64'(m_ready), 64'd2);
    tick();
    setMaster(1, 1'b0, 16'h0, 32'h0, 4'h0);
    applyStimulus("t3_m0");
    checkOutput("t3_m0", 64'(m_ready), 64'd1);
    tick();
    idleMasters();
    s_rvalid = 1'b1;
    s_rdata  = 32'h1234_5678;
    applyStimulus("t3_resp");
    checkOutput("t3_rvalid", 64'(m_rvalid), 64'd2);
    tick();
    s_rvalid = 1'b0;

    // 4: in-order responses routed to their masters
    setMaster(0, 1'b1, 16'h0100, 32'h0, 4'h0);
    applyStimulus("t4_rd0");
    tick();
    setMaster(0, 1'b0, 16'h0, 32'h0, 4'h0);
    setMaster(1, 1'b1, 16'h0200, 32'h0, 4'h0);
    applyStimulus("t4_rd1");
    tick();
    idleMasters();
    s_rvalid = 1'b1;
    s_rdata  = 32'hAAAA_0000;
    applyStimulus("t4_respA");
    checkOutput("t4_rvA", 64'(m_rvalid), 64'd1);
    checkOutput("t4_dataA", 64'(m_rdata), 64'hAAAA_0000);
    tick();
    s_rdata = 32'hBBBB_0000;
    applyStimulus("t4_respB");
    checkOutput("t4_rvB", 64'(m_rvalid), 64'd2);
    checkOutput("t4_dataB", 64'(m_rdata), 64'hBBBB_0000);
    tick();
    s_rvalid = 1'b0;

    // 5: full ID FIFO blocks reads but not writes
    for (int r = 0; r < 4; r++) begin
      idleMasters();
      setMaster(r % 2, 1'b1, 16'(16'h0400 + r), 32'h0, 4'h0);
      applyStimulus("t5_fill");
      tick();
    end
    idleMasters();
    setMaster(0, 1'b1, 16'h0500, 32'h0, 4'h0);
    setMaster(1, 1'b1, 16'h0600, 32'hCAFE_F00D, 4'hF);
    applyStimulus("t5_wr_pass");
    checkOutput("t5_wr_ready", 64'(m_ready), 64'd2);
    checkOutput("t5_wr_addr", 64'(s_addr), 64'h0600);
    tick();
    setMaster(1, 1'b0, 16'h0, 32'h0, 4'h0);
    applyStimulus("t5_blocked");
    checkOutput("t5_blocked", 64'(s_avalid), 64'd0);
    tick();
    s_rvalid = 1'b1;
    s_rdata  = 32'h5555_AAAA;
    applyStimulus("t5_swap");
    checkOutput("t5_swap_ready", 64'(m_ready), 64'd1);
    checkOutput("t5_swap_rvalid", 64'(m_rvalid), 64'd1);
    tick();
    s_rvalid = 1'b0;
    idleMasters();
    setMaster(1, 1'b1, 16'h0700, 32'h0, 4'h0);
    applyStimulus("t5_still_full");
    checkOutput("t5_still_full", 64'(s_avalid), 64'd0);
    tick();
    idleMasters();
    s_rvalid = 1'b1;
    for (int r = 0; r < 4; r++) begin
      s_rdata = $urandom;
      applyStimulus("t5_drain");
      tick();
    end
    s_rvalid = 1'b0;

    // randomized traffic; a stalled master keeps its request unchanged
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < N; k++) begin
        if (k != lock_m) begin
          rnd_strb = ($urandom_range(1, 0) == 1) ? '0 : SW'($urandom_range(15, 1));
          setMaster(k, $urandom_range(3, 0) != 0, 16'($urandom), $urandom, rnd_strb);
        end
      end
      s_ready  = $urandom_range(2, 0) != 0;
      s_rvalid = (id_q.size() > 0) && ($urandom_range(1, 0) == 1);
      s_rdata  = $urandom;
      applyStimulus("rand");
      tick();
    end

    // 6: reset drops in-flight reads; stray rvalid sets sticky error
    idleMasters();
    s_rvalid = 1'b0;
    s_ready  = 1'b1;
    setMaster(0, 1'b1, 16'h0800, 32'h0, 4'h0);
    applyStimulus("t6_rd");
    tick();
    doReset("t6_reset");
    s_rvalid = 1'b1;
    s_rdata  = 32'hDEAD_BEEF;
    applyStimulus("t6_stray");
    checkOutput("t6_stray_rvalid", 64'(m_rvalid), 64'd0);
    tick();
    s_rvalid = 1'b0;
    for (int c = 0; c < 2; c++) begin
      applyStimulus("t6_sticky");
      checkOutput("t6_err_set", 64'(err), 64'd1);
      tick();
    end
    doReset("t6_clear");
    checkOutput("t6_err_clear", 64'(err), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
